// File: rtl/sll_iter_pkg.sv
// ---------------------------------------------------------------------------
// sll_iter_pkg
// Shared definitions for the sequential left shifter/rotator:
//   - data and count widths
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - operation select encoding (SLL / ROL)
// ---------------------------------------------------------------------------
package sll_iter_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_ROL = 1'b1;

endpackage

// File: rtl/mux2_1.sv
// ---------------------------------------------------------------------------
// mux2_1
// Single-bit two-input multiplexer.
// Ports:
//   d0_i  - selected when sel_i = 0
//   d1_i  - selected when sel_i = 1
//   sel_i - select
//   y_o   - output
// ---------------------------------------------------------------------------
module mux2_1 (
    input  logic d0_i,
    input  logic d1_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/sll_1.sv
// ---------------------------------------------------------------------------
// sll_1
// Combinational one-position left shift with rotate select.
// Ports:
//   data_i [15:0] - operand
//   rot_i         - 0 = zero fill into bit 0, 1 = bit 15 wraps into bit 0
//   data_o [15:0] - shifted result
// ---------------------------------------------------------------------------
module sll_1
    import sll_iter_pkg::*;
(
    input  logic [WIDTH-1:0] data_i,
    input  logic             rot_i,
    output logic [WIDTH-1:0] data_o
);

    // Every output bit is a mux so the stage is uniform; above bit 0 both
    // legs carry the same neighbouring bit and the select is irrelevant.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic fill0;
            logic fill1;
            if (gi == 0) begin : g_lsb
                assign fill0 = 1'b0;
                assign fill1 = data_i[WIDTH-1];
            end else begin : g_upper
                assign fill0 = data_i[gi-1];
                assign fill1 = data_i[gi-1];
            end
            mux2_1 u_mux (
                .d0_i  (fill0),
                .d1_i  (fill1),
                .sel_i (rot_i),
                .y_o   (data_o[gi])
            );
        end
    endgenerate

endmodule

// File: rtl/sll_iter.sv
// ---------------------------------------------------------------------------
// sll_iter
// Sequential 16-bit logical-shift-left / rotate-left unit, one bit per clock,
// with a start/done handshake.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   start_i      - request, accepted only in IDLE or DONE
//   op_i         - 0 = SLL, 1 = ROL (captured on accept)
//   in_i  [15:0] - operand (captured on accept)
//   cnt_i [3:0]  - shift amount 0..15 (captured on accept)
//   out_o [15:0] - working/result data register
//   cout_o       - last bit shifted out of bit 15 (0 when cnt = 0)
//   busy_o       - high while shifting
//   done_o       - one-cycle pulse, out_o/cout_o valid
// ---------------------------------------------------------------------------
module sll_iter
    import sll_iter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [WIDTH-1:0] out_o,
    output logic             cout_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   rem_q;
    logic               op_q;
    logic               cout_q;
    logic [WIDTH-1:0]   shift_data;
    logic               accept;

    sll_1 u_stage (
        .data_i (data_q),
        .rot_i  (op_q == OP_ROL),
        .data_o (shift_data)
    );

    // DONE accepts a new request exactly like IDLE, giving back-to-back ops.
    assign accept = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (cnt_i != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                // Exit on the 1 -> 0 step so the counter never underflows.
                if (rem_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_d = (cnt_i != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= OP_SLL;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= in_i;
                rem_q  <= cnt_i;
                op_q   <= op_i;
                cout_q <= 1'b0;
            end else if (state_q == ST_SHIFT) begin
                data_q <= shift_data;
                cout_q <= data_q[WIDTH-1];
                rem_q  <= rem_q - 4'd1;
            end
        end
    end

    assign out_o  = data_q;
    assign cout_o = cout_q;
    assign busy_o = (state_q == ST_SHIFT);
    assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_sll_iter.sv
// ---------------------------------------------------------------------------
// tb_sll_iter
// Scoreboard bench for sll_iter: the driver pushes the expected result of
// each accepted request; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_sll_iter;

    typedef struct packed {
        logic [15:0] out;
        logic        cout;
        logic [4:0]  cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic [15:0] out_w;
    logic        cout_w;
    logic        busy_w;
    logic        done_w;

    int   vectors;
    int   fails;
    int   busy_cnt;
    exp_t sb_q[$];

    sll_iter dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .op_i    (op),
        .in_i    (din),
        .cnt_i   (cnt),
        .out_o   (out_w),
        .cout_o  (cout_w),
        .busy_o  (busy_w),
        .done_o  (done_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shift in a 32-bit field; the bits pushed past bit 15 are the
    // rotated-out bits, and bit 16 is the last one to leave.
    function automatic exp_t model(input logic o, input logic [15:0] d, input int n);
        logic [31:0] w;
        exp_t e;
        w      = {16'h0000, d} << n;
        e.out  = o ? (w[15:0] | w[31:16]) : w[15:0];
        e.cout = (n == 0) ? 1'b0 : w[16];
        e.cyc  = 5'(n);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge. Waits out SHIFT, then presents the request for one
    // edge. If the unit is in DONE this is a back-to-back issue.
    task automatic issue(input logic o, input logic [15:0] d, input int n);
        int g;
        g = 0;
        while (busy_w && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (busy_w) check("issue_timeout", 32'(busy_w), 32'd0);
        start = 1'b1;
        op    = o;
        din   = d;
        cnt   = 4'(n);
        sb_q.push_back(model(o, d, n));
        $display("issue op=%0d in=%h cnt=%0d", o, d, n);
        @(negedge clk);
        start = 1'b0;
        din   = 16'($urandom);
        cnt   = 4'($urandom);
        op    = 1'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out"},  32'(out_w),  32'h0);
        check({tag, "_cout"}, 32'(cout_w), 32'h0);
        check({tag, "_busy"}, 32'(busy_w), 32'h0);
        check({tag, "_done"}, 32'(done_w), 32'h0);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            busy_cnt = 0;
        end else begin
            if (busy_w) busy_cnt++;
            if (done_w) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done_w), 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    $display("done out=%h cout=%0d busy_cycles=%0d", out_w, cout_w, busy_cnt);
                    check("out",  32'(out_w),    32'(e.out));
                    check("cout", 32'(cout_w),   32'(e.cout));
                    check("busy", 32'(busy_cnt), 32'(e.cyc));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int g;
        vectors  = 0;
        fails    = 0;
        busy_cnt = 0;
        rst   = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        din   = 16'h0;
        cnt   = 4'h0;

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(1'b0, 16'h8001, 1);
        issue(1'b1, 16'h8001, 4);
        @(negedge clk);
        if (busy_w) begin
            start = 1'b1; op = 1'b0; din = 16'hFFFF; cnt = 4'd7;
            @(negedge clk);
            start = 1'b0;
        end
        issue(1'b0, 16'hABCD, 0);
        issue(1'b0, 16'hFFFF, 15);
        g = 0;
        while (busy_w && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("b2b_in_done", 32'(done_w), 32'd1);
        issue(1'b1, 16'h0001, 2);

        // Reset during a shift, after the third shift edge
        issue(1'b0, 16'h00FF, 8);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check("idle_busy", 32'(busy_w), 32'h0);
        check("idle_done", 32'(done_w), 32'h0);
        @(negedge clk);
        issue(1'b0, 16'h0003, 2);

        // Randomized requests, mixing back-to-back and idle gaps
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), 16'($urandom), int'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        g = 0;
        while (sb_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
